// File: rtl/delay_increment_comparator.sv
// delay_increment_comparator
// Per-element integer sample-delay tracker for a 63-element array (n = -31..31).
// Each focal point the upstream calculator supplies one signed comparator term per
// element pair (+n / -n, n = 0 first). The term is added to a per-element decision
// accumulator; when the sum reaches the next threshold (2*cnt+1) the element's
// delay advances by one sample. Updated delays stream out over a valid/ready port.
// Build option: define DELAY_SATURATE_EN to make delay counts saturate at their
// maximum (accumulator then left unreduced and overflow flagged); otherwise counts wrap.
`timescale 1ns/1ps
module delay_increment_comparator #(
  parameter int DW_INTEGER  = 18,
  parameter int DW_FRACTION = 8,
  parameter int DW_DELAY    = 12,
  parameter int N_HALF      = 32
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    configure,
  input  logic signed [DW_INTEGER+DW_FRACTION:0]  term_pos_n,
  input  logic signed [DW_INTEGER+DW_FRACTION:0]  term_neg_n,
  input  logic                                    term_ready,
  output logic                                    term_ack,
  output logic        [DW_DELAY-1:0]              delay_pos,
  output logic        [DW_DELAY-1:0]              delay_neg,
  output logic        [4:0]                       elem_idx,
  output logic        [15:0]                      point_idx,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic                                    overflow
);

  localparam int TW    = DW_INTEGER + DW_FRACTION + 1;
  localparam int AW    = TW + 2;
  localparam int THPAD = AW - DW_DELAY - 1 - DW_FRACTION;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_UPDATE, S_OUTPUT} state_t;

  typedef struct packed {
    logic [AW-1:0]       acc;
    logic [DW_DELAY-1:0] cnt;
    logic                ovf;
  } upd_t;

  state_t                     state_q;
  logic                       term_ack_q;
  logic                       out_valid_q;
  logic                       overflow_q;
  logic        [DW_DELAY-1:0] delay_pos_q;
  logic        [DW_DELAY-1:0] delay_neg_q;
  logic        [4:0]          elem_q;
  logic        [15:0]         point_q;
  logic signed [TW-1:0]       term_pos_q;
  logic signed [TW-1:0]       term_neg_q;

  logic signed [AW-1:0]       acc_pos_q [N_HALF];
  logic signed [AW-1:0]       acc_neg_q [N_HALF];
  logic        [DW_DELAY-1:0] cnt_pos_q [N_HALF];
  logic        [DW_DELAY-1:0] cnt_neg_q [N_HALF];

  upd_t                       upd_pos_d;
  upd_t                       upd_neg_d;
  logic                       is_center_d;
  logic        [DW_DELAY-1:0] delay_pos_d;
  logic        [DW_DELAY-1:0] delay_neg_d;
  logic                       ovf_d;

  // Threshold for the next delay step: (2*cnt+1) in accumulator fixed point.
  function automatic logic signed [AW-1:0] thresh(input logic [DW_DELAY-1:0] cnt);
    return $signed({{THPAD{1'b0}}, cnt, 1'b1, {DW_FRACTION{1'b0}}});
  endfunction

  // One decision step for one element: accumulate, compare, optionally advance.
  function automatic upd_t step(input logic signed [AW-1:0]       acc,
                                input logic signed [TW-1:0]       term,
                                input logic        [DW_DELAY-1:0] cnt);
    logic signed [AW-1:0]   s;
    logic signed [AW-1:0]   th;
    logic signed [AW-1:0]   rem;
    logic [DW_DELAY-1:0]    cnt_nx;
    upd_t                   r;
    s      = acc + $signed({{(AW-TW){term[TW-1]}}, term});
    th     = thresh(cnt);
    rem    = s - th;
    cnt_nx = cnt + DW_DELAY'(1);
    r.acc  = s;
    r.cnt  = cnt;
    r.ovf  = 1'b0;
    if (s >= th) begin
`ifdef DELAY_SATURATE_EN
      if (&cnt) begin
        r.ovf = 1'b1;
      end else begin
        r.acc = rem;
        r.cnt = cnt_nx;
        r.ovf = (rem >= thresh(cnt_nx));
      end
`else
      r.acc = rem;
      r.cnt = cnt_nx;
      r.ovf = (rem >= thresh(cnt_nx));
`endif
    end
    return r;
  endfunction

  // Compute the updated state of the current element pair from the captured terms.
  always_comb begin
    upd_pos_d   = step(acc_pos_q[elem_q], term_pos_q, cnt_pos_q[elem_q]);
    upd_neg_d   = step(acc_neg_q[elem_q], term_neg_q, cnt_neg_q[elem_q]);
    is_center_d = (elem_q == '0);
    delay_pos_d = upd_pos_d.cnt;
    delay_neg_d = is_center_d ? upd_pos_d.cnt : upd_neg_d.cnt;
    ovf_d       = upd_pos_d.ovf | (~is_center_d & upd_neg_d.ovf);
  end

  // Per-element accumulator/count storage; the centre element lives in the pos bank only.
  always_ff @(posedge clk) begin
    if (rst || configure) begin
      for (int i = 0; i < N_HALF; i++) begin
        acc_pos_q[i] <= '0;
        acc_neg_q[i] <= '0;
        cnt_pos_q[i] <= '0;
        cnt_neg_q[i] <= '0;
      end
    end else if (state_q == S_UPDATE) begin
      acc_pos_q[elem_q] <= $signed(upd_pos_d.acc);
      cnt_pos_q[elem_q] <= upd_pos_d.cnt;
      if (!is_center_d) begin
        acc_neg_q[elem_q] <= $signed(upd_neg_d.acc);
        cnt_neg_q[elem_q] <= upd_neg_d.cnt;
      end
    end
  end

  // Term capture registers: loaded on the accepted upstream handshake.
  always_ff @(posedge clk) begin
    if (state_q == S_CAPTURE && term_ready && !rst && !configure) begin
      term_pos_q <= term_pos_n;
      term_neg_q <= term_neg_n;
    end
  end

  // Control FSM with registered handshakes, output delays and element/point indices.
  always_ff @(posedge clk) begin
    if (rst || configure) begin
      state_q     <= rst ? S_IDLE : S_CAPTURE;
      term_ack_q  <= 1'b0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      delay_pos_q <= '0;
      delay_neg_q <= '0;
      elem_q      <= '0;
      point_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          term_ack_q <= 1'b0;
        end
        S_CAPTURE: begin
          if (term_ready) begin
            term_ack_q <= 1'b1;
            state_q    <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          term_ack_q  <= 1'b0;
          out_valid_q <= 1'b1;
          delay_pos_q <= delay_pos_d;
          delay_neg_q <= delay_neg_d;
          overflow_q  <= overflow_q | ovf_d;
          state_q     <= S_OUTPUT;
        end
        S_OUTPUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_CAPTURE;
            if (elem_q == 5'(N_HALF - 1)) begin
              elem_q  <= '0;
              point_q <= point_q + 16'd1;
            end else begin
              elem_q  <= elem_q + 5'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign term_ack  = term_ack_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;
  assign delay_pos = delay_pos_q;
  assign delay_neg = delay_neg_q;
  assign elem_idx  = elem_q;
  assign point_idx = point_q;

endmodule

// File: tb/tb_delay_increment_comparator.sv
// Bench for delay_increment_comparator, built with a 4-bit delay count so that
// count saturation/wrap is reachable. Honours DELAY_SATURATE_EN like the design.
`timescale 1ns/1ps
module tb_delay_increment_comparator;

  localparam int TW   = 27;
  localparam int DWD  = 4;
  localparam int NH   = 32;
  localparam int CMAX = 1 << DWD;
`ifdef DELAY_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 configure;
  logic signed [TW-1:0] term_pos_n;
  logic signed [TW-1:0] term_neg_n;
  logic                 term_ready;
  logic                 term_ack;
  logic [DWD-1:0]       delay_pos;
  logic [DWD-1:0]       delay_neg;
  logic [4:0]           elem_idx;
  logic [15:0]          point_idx;
  logic                 out_valid;
  logic                 out_ready;
  logic                 overflow;

  delay_increment_comparator #(.DW_DELAY(DWD)) dut (
    .clk(clk), .rst(rst), .configure(configure),
    .term_pos_n(term_pos_n), .term_neg_n(term_neg_n),
    .term_ready(term_ready), .term_ack(term_ack),
    .delay_pos(delay_pos), .delay_neg(delay_neg),
    .elem_idx(elem_idx), .point_idx(point_idx),
    .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: real-valued accumulators in units of 1/256, integer counts.
  longint acc_m [2][NH];
  int     cnt_m [2][NH];
  bit     ovf_m;
  int     elem_m;
  int     pt_m;
  int     obs_pos, obs_neg;
  int     prev0;
  bit     seen_wrap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < NH; i++) begin
        acc_m[b][i] = 0;
        cnt_m[b][i] = 0;
      end
    ovf_m  = 1'b0;
    elem_m = 0;
    pt_m   = 0;
  endtask

  // Decision rule: add term; if the sum reaches (2*cnt+1) advance the delay once.
  task automatic model_elem(input int b, input longint term);
    longint s, th;
    int n;
    n  = elem_m;
    s  = acc_m[b][n] + term;
    th = longint'(2 * cnt_m[b][n] + 1) * 256;
    if (s >= th) begin
      if (SAT && cnt_m[b][n] == CMAX - 1) begin
        acc_m[b][n] = s;
        ovf_m = 1'b1;
      end else begin
        cnt_m[b][n] = (cnt_m[b][n] + 1) % CMAX;
        acc_m[b][n] = s - th;
        if (acc_m[b][n] >= longint'(2 * cnt_m[b][n] + 1) * 256) ovf_m = 1'b1;
      end
    end else begin
      acc_m[b][n] = s;
    end
  endtask

  function automatic longint rnd_term();
    return longint'($urandom_range(0, 1536)) - 256;
  endfunction

  // One full term transaction; 'hold' cycles of downstream backpressure.
  task automatic do_term(input longint pos, input longint neg, input int hold);
    int ep, en;
    term_pos_n = pos[TW-1:0];
    term_neg_n = neg[TW-1:0];
    term_ready = 1'b1;
    out_ready  = (hold == 0);
    @(posedge clk); #1;
    chk("ack_pulse", 32'(term_ack), 32'd1);
    chk("valid_before_update", 32'(out_valid), 32'd0);
    if (hold == 0) term_ready = 1'b0;
    model_elem(0, pos);
    if (elem_m != 0) model_elem(1, neg);
    ep = cnt_m[0][elem_m];
    en = (elem_m == 0) ? ep : cnt_m[1][elem_m];
    @(posedge clk); #1;
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("ack_dropped", 32'(term_ack), 32'd0);
    chk("delay_pos", 32'(delay_pos), 32'(ep));
    chk("delay_neg", 32'(delay_neg), 32'(en));
    chk("elem_idx", 32'(elem_idx), 32'(elem_m));
    chk("point_idx", 32'(point_idx), 32'(pt_m));
    chk("overflow", 32'(overflow), 32'(ovf_m));
    obs_pos = int'(delay_pos);
    obs_neg = int'(delay_neg);
    if (elem_m == 0) begin
      if (prev0 == CMAX - 1 && obs_pos == 0) seen_wrap = 1'b1;
      prev0 = obs_pos;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_no_ack", 32'(term_ack), 32'd0);
      chk("hold_delay", 32'(delay_pos), 32'(ep));
      chk("hold_elem", 32'(elem_idx), 32'(elem_m));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("valid_after_hs", 32'(out_valid), 32'd0);
    chk("no_ack_after_hs", 32'(term_ack), 32'd0);
    term_ready = 1'b0;
    elem_m = (elem_m + 1) % NH;
    if (elem_m == 0) pt_m = (pt_m + 1) % 65536;
  endtask

  task automatic pulse_configure();
    configure = 1'b1;
    @(posedge clk); #1;
    configure = 1'b0;
    model_reset();
    prev0 = 0;
    seen_wrap = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; configure = 1'b0; term_ready = 1'b0; out_ready = 1'b1;
    term_pos_n = '0; term_neg_n = '0;
    model_reset();
    prev0 = 0; seen_wrap = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(term_ack), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_delay_pos", 32'(delay_pos), 32'd0);
    chk("rst_delay_neg", 32'(delay_neg), 32'd0);
    chk("rst_elem", 32'(elem_idx), 32'd0);
    chk("rst_point", 32'(point_idx), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;

    // Idle until configured: terms are ignored
    term_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_no_ack", 32'(term_ack), 32'd0);
    end
    term_ready = 1'b0;

    // Centre element, term 3.0
    pulse_configure();
    do_term(64'sh300, 64'sh300, 0);
    chk("t2_delay_pos", 32'(obs_pos), 32'd1);
    chk("t2_delay_neg", 32'(obs_neg), 32'd1);

    // n=1 with 0.5 / 1.5
    do_term(64'sh080, 64'sh180, 0);
    chk("t3_pos", 32'(obs_pos), 32'd0);
    chk("t3_neg", 32'(obs_neg), 32'd1);

    // Rest of point 0, random terms, 10 cycles of backpressure at element 5
    while (elem_m != 0) do_term(rnd_term(), rnd_term(), (elem_m == 5) ? 10 : 0);

    // Point 1 centre term 2.0: acc 4.0 >= 3.0 -> delay 2
    do_term(64'sh200, 64'sh200, 0);
    chk("t3_second_step", 32'(obs_pos), 32'd2);

    // Rest of point 1 and into point 2
    while (elem_m != 0) do_term(rnd_term(), rnd_term(), 0);
    repeat (3) do_term(rnd_term(), rnd_term(), 0);

    // Configure during UPDATE aborts the term
    term_pos_n = 27'sh400; term_neg_n = 27'sh400; term_ready = 1'b1;
    @(posedge clk); #1;
    chk("abort_ack", 32'(term_ack), 32'd1);
    configure = 1'b1; term_ready = 1'b0;
    @(posedge clk); #1;
    configure = 1'b0;
    chk("abort_ack_clear", 32'(term_ack), 32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_delay", 32'(delay_pos), 32'd0);
    chk("abort_elem", 32'(elem_idx), 32'd0);
    chk("abort_point", 32'(point_idx), 32'd0);
    chk("abort_overflow", 32'(overflow), 32'd0);
    @(posedge clk); #1;
    chk("abort_no_valid", 32'(out_valid), 32'd0);
    model_reset();
    prev0 = 0; seen_wrap = 1'b0;

    // Configure in the same cycle as term_ready: configure wins
    term_ready = 1'b1; configure = 1'b1;
    @(posedge clk); #1;
    configure = 1'b0; term_ready = 1'b0;
    chk("cfg_wins_ack", 32'(term_ack), 32'd0);
    @(posedge clk); #1;
    chk("cfg_wins_ack2", 32'(term_ack), 32'd0);
    chk("cfg_wins_valid", 32'(out_valid), 32'd0);

    // Counts restart from zero
    do_term(64'sh300, 64'sh300, 0);
    chk("after_cfg_delay", 32'(obs_pos), 32'd1);

    // Large centre terms over many points: saturation or wrap of the delay count
    pulse_configure();
    for (int p = 0; p < 18; p++) begin
      do_term(64'sh2800, 64'sh2800, 0);
      while (elem_m != 0) do_term(rnd_term(), rnd_term(), 0);
    end
    if (SAT) begin
      chk("sat_delay", 32'(prev0), 32'(CMAX - 1));
      chk("sat_overflow", 32'(overflow), 32'd1);
    end else begin
      chk("wrap_seen", 32'(seen_wrap), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
